// File: rtl/pcc_seq_ctrl.sv
// pcc_seq_ctrl: sequencer for a time-multiplexed popcount comparator.
// Streams a pos/neg vector pair CHUNK bits per cycle through a popcount slice
// pair, accumulates both counts and reports outval = (cnt_pos >= cnt_neg).
// Optional feature macro: PCC_EARLY_TERM_EN. When it is defined, RUN stops as
// soon as the remaining bits can no longer change the vote.

// Popcount of one CHUNK-wide slice, zero-extended to the accumulator width.
module pcc_popcnt_slice #(
    parameter int CHUNK = 2,
    parameter int CW    = 5
) (
    input  logic [CHUNK-1:0] bits,
    output logic [CW-1:0]    cnt
);
    // Adder chain over the slice bits.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < CHUNK; i++) cnt = cnt + CW'(bits[i]);
    end
endmodule

module pcc_seq_ctrl #(
    parameter  int N_BITS = 16,
    parameter  int CHUNK  = 2,
    localparam int CW     = $clog2(N_BITS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_BITS-1:0] pos,
    input  logic [N_BITS-1:0] neg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              outval,
    output logic [CW-1:0]     cnt_pos,
    output logic [CW-1:0]     cnt_neg
);
    localparam int BEATS = N_BITS / CHUNK;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                 state;
    logic [N_BITS-1:0]      sh_pos, sh_neg;
    logic [BW-1:0]          beat;
    logic [1:0][CHUNK-1:0]  slice_in;
    logic [1:0][CW-1:0]     slice_cnt;
    logic [CW-1:0]          nxt_pos, nxt_neg;
    logic                   decided;

    // Lane 0 counts pos, lane 1 counts neg; both see the low chunk of their shift reg.
    assign slice_in[0] = sh_pos[CHUNK-1:0];
    assign slice_in[1] = sh_neg[CHUNK-1:0];

    for (genvar g = 0; g < 2; g++) begin : g_slice
        pcc_popcnt_slice #(.CHUNK(CHUNK), .CW(CW)) u_slice (
            .bits (slice_in[g]),
            .cnt  (slice_cnt[g])
        );
    end

    // Accumulator values after this beat's chunk is added.
    always_comb begin
        nxt_pos = cnt_pos + slice_cnt[0];
        nxt_neg = cnt_neg + slice_cnt[1];
    end

`ifdef PCC_EARLY_TERM_EN
    logic [CW:0] remain;
    // Vote is settled once the unconsumed bits cannot flip it; remain is 0 on the last beat.
    always_comb begin
        remain  = (CW+1)'(N_BITS - CHUNK) - (CW+1)'(beat) * (CW+1)'(CHUNK);
        decided = ({1'b0, nxt_pos} >= {1'b0, nxt_neg} + remain) ||
                  ({1'b0, nxt_pos} + remain < {1'b0, nxt_neg});
    end
`else
    // Full run: finish only after the last beat.
    always_comb decided = (beat == BW'(BEATS - 1));
`endif

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            outval    <= 1'b0;
            cnt_pos   <= '0;
            cnt_neg   <= '0;
            sh_pos    <= '0;
            sh_neg    <= '0;
            beat      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        sh_pos   <= pos;
                        sh_neg   <= neg;
                        cnt_pos  <= '0;
                        cnt_neg  <= '0;
                        beat     <= '0;
                        outval   <= 1'b1;   // cleared counts tie 0/0
                        in_ready <= 1'b0;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    cnt_pos <= nxt_pos;
                    cnt_neg <= nxt_neg;
                    outval  <= (nxt_pos >= nxt_neg);
                    sh_pos  <= sh_pos >> CHUNK;
                    sh_neg  <= sh_neg >> CHUNK;
                    beat    <= beat + BW'(1);
                    if (decided) begin
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pcc_seq_ctrl.sv
// Scoreboard bench for pcc_seq_ctrl (N_BITS=8, CHUNK=2) plus a BEATS=1 instance.
module tb_pcc_seq_ctrl;
    localparam int N     = 8;
    localparam int C     = 2;
    localparam int BEATS = N / C;
    localparam int CW    = $clog2(N + 1);
    localparam int N1    = 4;
    localparam int CW1   = $clog2(N1 + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, outval;
    logic [N-1:0]  pos = '0, neg = '0;
    logic [CW-1:0] cnt_pos, cnt_neg;

    logic in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b1, outval1;
    logic [N1-1:0]  pos1 = '0, neg1 = '0;
    logic [CW1-1:0] cnt_pos1, cnt_neg1;

    pcc_seq_ctrl #(.N_BITS(N), .CHUNK(C)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pos(pos), .neg(neg), .out_valid(out_valid), .out_ready(out_ready),
        .outval(outval), .cnt_pos(cnt_pos), .cnt_neg(cnt_neg)
    );

    pcc_seq_ctrl #(.N_BITS(N1), .CHUNK(N1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .pos(pos1), .neg(neg1), .out_valid(out_valid1), .out_ready(out_ready1),
        .outval(outval1), .cnt_pos(cnt_pos1), .cnt_neg(cnt_neg1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] p;
        logic [CW-1:0] n;
        logic          ov;
        int            t;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   rdy_mode = 1;   // 0: out_ready low, 1: high, 2: random

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: walk the vectors chunk by chunk with integer counts.
    function automatic exp_t model(input logic [N-1:0] p, input logic [N-1:0] q, input int t);
        exp_t e;
        int cp = 0, cn = 0, used = BEATS;
        for (int k = 0; k < BEATS; k++) begin
            for (int b = 0; b < C; b++) begin
                cp += int'(p[k*C+b]);
                cn += int'(q[k*C+b]);
            end
`ifdef PCC_EARLY_TERM_EN
            begin
                int r = N - (k + 1) * C;
                if (cp >= cn + r || cp + r < cn) begin
                    used = k + 1;
                    break;
                end
            end
`endif
        end
        e.p   = CW'(cp);
        e.n   = CW'(cn);
        e.ov  = (cp >= cn);
        e.t   = t;
        e.lat = used + 1;
        return e;
    endfunction

    // Monitor: checks handshake levels and results every cycle, issues expectations on accept.
    initial begin
        bit prev_rst = 1'b1;
        bit exp_ov;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                prev_rst = 1'b1;
            end else begin
                if (prev_rst) begin
                    chk("rst_out_valid", 32'(out_valid), 32'(0));
                    chk("rst_cnt_pos", 32'(cnt_pos), 32'(0));
                    chk("rst_cnt_neg", 32'(cnt_neg), 32'(0));
                    chk("rst_outval", 32'(outval), 32'(0));
                end
                prev_rst = 1'b0;
                chk("in_ready", 32'(in_ready), 32'(sb.size() == 0));
                exp_ov = (sb.size() > 0) && (cyc >= sb[0].t + sb[0].lat);
                chk("out_valid", 32'(out_valid), 32'(exp_ov));
                if (out_valid && sb.size() > 0) begin
                    chk("cnt_pos", 32'(cnt_pos), 32'(sb[0].p));
                    chk("cnt_neg", 32'(cnt_neg), 32'(sb[0].n));
                    chk("outval", 32'(outval), 32'(sb[0].ov));
                    if (out_ready) void'(sb.pop_front());
                end
                if (in_valid && in_ready) sb.push_back(model(pos, neg, cyc));
            end
        end
    end

    // out_ready driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 2) == 0);
            endcase
        end
    end

    task automatic send(input logic [N-1:0] p, input logic [N-1:0] q);
        int w = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; pos = p; neg = q;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", w);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        @(negedge clk);
        while (!(sb.size() == 0 && in_ready) && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d results pending after %0d cycles", sb.size(), w);
        end
    endtask

    // Single-beat instance: result one cycle after the RUN cycle.
    task automatic one_beat(input logic [N1-1:0] p, input logic [N1-1:0] q);
        int ep = $countones(p), en = $countones(q);
        @(posedge clk); #1;
        chk("b1_in_ready_idle", 32'(in_ready1), 32'(1));
        in_valid1 = 1'b1; pos1 = p; neg1 = q;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        @(negedge clk);
        chk("b1_out_valid_run", 32'(out_valid1), 32'(0));
        @(negedge clk);
        chk("b1_out_valid_done", 32'(out_valid1), 32'(1));
        chk("b1_cnt_pos", 32'(cnt_pos1), 32'(ep));
        chk("b1_cnt_neg", 32'(cnt_neg1), 32'(en));
        chk("b1_outval", 32'(outval1), 32'(ep >= en));
        @(negedge clk);
        chk("b1_in_ready_back", 32'(in_ready1), 32'(1));
        chk("b1_out_valid_back", 32'(out_valid1), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Result held while out_ready stays low.
        rdy_mode = 0;
        send(8'hB5, 8'h0F);
        begin
            int w = 0;
            while (!out_valid && w < 20) begin
                @(negedge clk);
                w++;
            end
        end
        repeat (3) @(posedge clk);
        #1 rdy_mode = 1;
        drain();

        // Loss, tie, all-zero.
        send(8'h01, 8'h03);
        send(8'hFF, 8'hFF);
        send(8'h00, 8'h00);
        drain();

        // Reset on the second RUN beat drops the result.
        send(8'hFF, 8'h00);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        send(8'h3C, 8'h11);
        drain();

        // in_valid held high with changing data: only handshaken pairs count.
        @(posedge clk); #1;
        in_valid = 1'b1;
        repeat (3 * (BEATS + 2) + 2) begin
            pos = 8'($urandom);
            neg = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();

        // Randomized traffic with random backpressure.
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            case (i % 8)
                0:       send(8'hFF, 8'($urandom));
                1:       send(8'($urandom), 8'h00);
                default: send(8'($urandom), 8'($urandom));
            endcase
        end
        rdy_mode = 1;
        drain();

        // BEATS=1 instance.
        one_beat(4'hF, 4'h0);
        one_beat(4'h3, 4'h7);
        one_beat(4'h0, 4'h0);

        chk("scoreboard_empty", 32'(sb.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
